nbitadd_sched: RTL

Two-requester scheduler for the shared `nbitadd` ripple adder.
- Accepts wide additions of `WORDS*BITS` bits from two requesters and arbitrates them round-robin.
- Runs each operation through one external `BITS`-wide `nbitadd` instance, one chunk per cycle, chaining the carry between chunks.
- Returns the wide sum and carry-out on a valid/ready result port.
- Sits between the requesting units and the adder, which it drives directly.

---
 rtl/nbitadd_sched_if.sv | 50 +++++
 rtl/nbitadd_sched.sv | 93 +++++++++
 2 files changed

// File: rtl/nbitadd_sched_if.sv
// Signal bundle between nbitadd_sched, its two requesters, the result consumer
// and the shared BITS-wide nbitadd instance.
interface nbitadd_sched_if #(
   parameter int BITS  = 7,
   parameter int WORDS = 4
);
   localparam int W = BITS * WORDS;

   logic            req0_valid;
   logic            req0_ready;
   logic [W-1:0]    req0_a;
   logic [W-1:0]    req0_b;
   logic            req0_cin;

   logic            req1_valid;
   logic            req1_ready;
   logic [W-1:0]    req1_a;
   logic [W-1:0]    req1_b;
   logic            req1_cin;

   logic [BITS-1:0] add_a;
   logic [BITS-1:0] add_b;
   logic            add_cin;
   logic [BITS-1:0] add_s;
   logic [BITS-1:0] add_c;

   logic            res_valid;
   logic            res_ready;
   logic [W-1:0]    res_sum;
   logic            res_cout;
   logic            res_id;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin,
      input  req1_valid, req1_a, req1_b, req1_cin,
      input  add_s, add_c, res_ready,
      output req0_ready, req1_ready,
      output add_a, add_b, add_cin,
      output res_valid, res_sum, res_cout, res_id
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_cin,
      output req1_valid, req1_a, req1_b, req1_cin,
      output add_s, add_c, res_ready,
      input  req0_ready, req1_ready,
      input  add_a, add_b, add_cin,
      input  res_valid, res_sum, res_cout, res_id
   );
endinterface

// File: rtl/nbitadd_sched.sv
// Round-robin scheduler that runs WORDS*BITS-bit additions from two requesters
// through one shared BITS-wide nbitadd, one chunk per cycle with chained carry.
module nbitadd_sched #(
   parameter int BITS  = 7,
   parameter int WORDS = 4
) (
   input logic clk,
   input logic rst_n,
   nbitadd_sched_if.slave bus
);
   localparam int W  = BITS * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [KW-1:0] k;
   logic [W-1:0]  a_q, b_q, sum_q;
   logic          cin_q, carry_q, cout_q, id_q, last_q;
   logic          gnt, take;
   logic          unused_ok;

   // Both valid: serve the one not granted last; otherwise the lone valid one.
   assign gnt  = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
   assign take = rst_n && (state == IDLE) && (bus.req0_valid || bus.req1_valid);

   assign bus.req0_ready = take & ~gnt;
   assign bus.req1_ready = take & gnt;

   assign bus.res_valid = (state == DONE);
   assign bus.res_sum   = sum_q;
   assign bus.res_cout  = cout_q;
   assign bus.res_id    = id_q;

   assign unused_ok = &{1'b0, bus.add_c};

   always_comb begin
      state_nx    = state;
      bus.add_a   = '0;
      bus.add_b   = '0;
      bus.add_cin = 1'b0;
      case (state)
         IDLE: if (take) state_nx = RUN;
         RUN: begin
            bus.add_a   = a_q[k*BITS +: BITS];
            bus.add_b   = b_q[k*BITS +: BITS];
            bus.add_cin = (k == '0) ? cin_q : carry_q;
            if (k == KLAST) state_nx = DONE;
         end
         DONE: if (bus.res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         k       <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (take) begin
               a_q    <= gnt ? bus.req1_a   : bus.req0_a;
               b_q    <= gnt ? bus.req1_b   : bus.req0_b;
               cin_q  <= gnt ? bus.req1_cin : bus.req0_cin;
               id_q   <= gnt;
               last_q <= gnt;
               k      <= '0;
            end
            RUN: begin
               sum_q[k*BITS +: BITS] <= bus.add_s;
               carry_q               <= bus.add_c[BITS-1];
               if (k == KLAST) begin
                  cout_q <= bus.add_c[BITS-1];
                  k      <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
